// File: rtl/dual_rail_checker_if.sv
// Bundles the dual-rail pair, the clear request and the checked outputs of dual_rail_checker.
interface dual_rail_checker_if #(
  parameter int ERR_CNT_W = 8
);
  logic                 rail0;
  logic                 rail1;
  logic                 clear_err;
  logic                 d_out;
  logic                 d_valid;
  logic                 fault;
  logic [ERR_CNT_W-1:0] err_count;

  modport master (
    output rail0, rail1, clear_err,
    input  d_out, d_valid, fault, err_count
  );

  modport slave (
    input  rail0, rail1, clear_err,
    output d_out, d_valid, fault, err_count
  );
endinterface

// File: rtl/dual_rail_checker.sv
// Receives a complementary dual-rail pair, synchronises it, recovers the data bit and
// tracks invalid (non-complementary) samples with a saturating count and a sticky fault.
module dual_rail_checker #(
  parameter int SYNC_STAGES = 2,
  parameter int ERR_CNT_W   = 8,
  parameter int FAULT_LIMIT = 3
) (
  input logic                clk,
  input logic                reset,
  dual_rail_checker_if.slave bus
);
  localparam int RUN_W  = $clog2(FAULT_LIMIT + 1);
  localparam int WARM_W = $clog2(SYNC_STAGES + 1);
  localparam logic [RUN_W-1:0]     RUN_LIMIT = RUN_W'(FAULT_LIMIT);
  localparam logic [WARM_W-1:0]    WARM_LAST = WARM_W'(SYNC_STAGES - 1);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX   = '1;

  typedef enum logic [1:0] {WARMUP, OK, SUSPECT, FAULT} state_t;

  logic [SYNC_STAGES-1:0] sync0, sync1;
  logic                   s0, s1, valid;
  state_t                 state, state_n;
  logic [RUN_W-1:0]       run, run_n;
  logic [WARM_W-1:0]      warm, warm_n;
  logic                   d_out_q, d_out_n;
  logic                   d_valid_q, d_valid_n;
  logic [ERR_CNT_W-1:0]   err_q, err_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync0 <= '0;
      sync1 <= '0;
    end else begin
      sync0 <= {sync0[SYNC_STAGES-2:0], bus.rail0};
      sync1 <= {sync1[SYNC_STAGES-2:0], bus.rail1};
    end
  end

  assign s0    = sync0[SYNC_STAGES-1];
  assign s1    = sync1[SYNC_STAGES-1];
  assign valid = s0 ^ s1;

  // clear_err outranks the increment; WARMUP ignores samples but still honours a clear.
  always_comb begin
    state_n   = state;
    run_n     = run;
    warm_n    = warm;
    d_out_n   = d_out_q;
    d_valid_n = 1'b0;
    err_n     = err_q;

    if (state != WARMUP && !valid && err_q != ERR_MAX)
      err_n = err_q + ERR_CNT_W'(1);
    if (bus.clear_err)
      err_n = '0;

    case (state)
      WARMUP: begin
        if (warm == WARM_LAST)
          state_n = OK;
        else
          warm_n = warm + WARM_W'(1);
      end
      OK: begin
        if (valid) begin
          d_out_n   = s0;
          d_valid_n = 1'b1;
        end else if (FAULT_LIMIT == 1) begin
          state_n = FAULT;
        end else begin
          state_n = SUSPECT;
          run_n   = RUN_W'(1);
        end
      end
      SUSPECT: begin
        if (valid) begin
          d_out_n   = s0;
          d_valid_n = 1'b1;
          state_n   = OK;
          run_n     = '0;
        end else begin
          run_n = run + RUN_W'(1);
          if (run_n == RUN_LIMIT)
            state_n = FAULT;
        end
      end
      FAULT: begin
        if (bus.clear_err && valid) begin
          state_n = OK;
          run_n   = '0;
        end
      end
      default: state_n = WARMUP;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= WARMUP;
      run       <= '0;
      warm      <= '0;
      d_out_q   <= 1'b0;
      d_valid_q <= 1'b0;
      err_q     <= '0;
    end else begin
      state     <= state_n;
      run       <= run_n;
      warm      <= warm_n;
      d_out_q   <= d_out_n;
      d_valid_q <= d_valid_n;
      err_q     <= err_n;
    end
  end

  assign bus.d_out     = d_out_q;
  assign bus.d_valid   = d_valid_q;
  assign bus.fault     = (state == FAULT);
  assign bus.err_count = err_q;
endmodule

// File: doc/dual_rail_checker.md
# dual_rail_checker

- Receive end of the complementary-output flip-flop interface.
- Takes a dual-rail pair (rail0, rail1) driven by an upstream complementary flop, synchronises it into the local clock domain, and recovers the data bit.
- Checks that the two rails stay complementary, counts invalid samples, and raises a sticky fault after a run of consecutive invalid samples.
- Sits between dual-rail flop outputs and downstream logic that needs a checked single-rail bit.

## Interface
- SYNC_STAGES, 2, synchroniser depth per rail (≥2).
- ERR_CNT_W, 8, width of err_count.
- FAULT_LIMIT, 3, consecutive invalid samples that force FAULT (≥1).

Ports:
- clk  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- rail0  in  1  true rail (asynchronous to clk).
- rail1  in  1  complement rail (asynchronous to clk).
- clear_err  in  1  synchronous, single-cycle request to clear err_count and release FAULT.
- d_out  out  1  recovered data bit, registered.
- d_valid  out  1  d_out was loaded from a valid sample this cycle, registered.
- fault  out  1  sticky fault flag; high exactly while state is FAULT.
- err_count  out  ERR_CNT_W  saturating count of invalid samples.

## Operation
- Each rail passes through its own SYNC_STAGES-deep flop chain; all sync flops reset to 0.
- The sample is the pair (s0, s1) at the final sync stage.
- A sample is valid when s0 != s1; the data value is s0.
- States are WARMUP, OK, SUSPECT and FAULT; reset enters WARMUP.
- WARMUP:
  - counts SYNC_STAGES cycles, then moves to OK;
  - samples are ignored (no counting, d_valid=0).
- OK:
  - invalid sample → SUSPECT with run=1, or → FAULT if FAULT_LIMIT==1;
  - valid sample → stay in OK.
- SUSPECT:
  - valid sample → OK and run=0;
  - invalid sample → run+1; when run reaches FAULT_LIMIT → FAULT.
- FAULT:
  - stays until a cycle with clear_err=1 and a valid sample, then → OK;
  - clear_err with an invalid sample clears err_count but stays in FAULT.
- d_out / d_valid:
  - in OK or SUSPECT, a valid sample loads d_out←s0 and sets d_valid=1;
  - otherwise d_out holds and d_valid=0;
  - on the FAULT→OK exit cycle d_valid=0.
- err_count:
  - in OK, SUSPECT and FAULT, +1 per invalid sample, saturating at 2^ERR_CNT_W−1;
  - clear_err forces 0 and has priority over a simultaneous increment;
  - clear_err has no effect on state outside FAULT.
- clear_err during WARMUP clears err_count only.
- Run counter width is clog2(FAULT_LIMIT+1).

## Timing
- Reset values: d_out=0, d_valid=0, fault=0, err_count=0, run=0, sync flops 0, state WARMUP.
- Reset is asynchronous on assertion; deassertion is used as-is (upstream deasserts reset synchronously to clk).
- Latency: a rail change before edge N appears at the sample after edge N+SYNC_STAGES−1. The resulting d_out, d_valid, err_count, fault and state update on edge N+SYNC_STAGES, i.e. SYNC_STAGES+1 edges total.
- First possible d_valid=1 is at edge SYNC_STAGES+1 after reset release.
- fault rises on the same edge the FAULT_LIMIT-th consecutive invalid sample is registered. It falls on the edge that registers clear_err with a valid sample.
- Reset mid-operation: all outputs return to reset values immediately; err_count is lost.
- One isolated invalid sample (shorter than FAULT_LIMIT) only increments err_count; fault stays 0.

## Test plan
- Reset, then hold rail0=1, rail1=0 → d_valid=1 and d_out=1 from edge 3 after release (SYNC_STAGES=2); err_count=0, fault=0.
- In OK, drive rails 11 for 2 cycles, then 01 → err_count=2, fault stays 0, state returns to OK, d_out=0, d_valid=1.
- Drive rails 00 for 3 cycles (FAULT_LIMIT=3) → fault=1 on the 3rd invalid sample, err_count=3, d_valid=0, d_out holds its last value.
- In FAULT with rails 00, pulse clear_err → err_count=0, fault stays 1. Then restore 10 and pulse clear_err → fault=0, d_valid=0 that cycle, and d_valid=1 with d_out=1 the next cycle.
- With ERR_CNT_W=2, hold rails 11 for 6 cycles → err_count saturates at 3; clear_err on the same cycle as an invalid sample → err_count=0.
- Assert reset mid-SUSPECT with err_count=1 → all outputs 0 immediately; after release, WARMUP lasts 2 cycles before checking resumes.
